sequence_word_serializer: RTL and testbench

//  Upstream feeder for sequence_detector_1011. Accepts parallel words over a valid/ready handshake.

---
 rtl/seq_detect_pkg.sv | 15 +
 rtl/serializer_shift_reg.sv | 47 ++++
 rtl/sequence_word_serializer.sv | 106 ++++++++++
 tb/tb_sequence_word_serializer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the 1011 sequence detector and its word serializer feeder.
// Holds state encodings, the default word width and the detection pattern.
package seq_detect_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    localparam int DEFAULT_WIDTH = 8;

    localparam int             DETECT_LEN     = 4;
    localparam logic [3:0]     DETECT_PATTERN = 4'b1011;

endpackage

// File: rtl/serializer_shift_reg.sv
// Holds the not-yet-sent bits of the current word and presents the next bit to send.
// On load the first bit is passed straight through, so the register only keeps the remainder.
module serializer_shift_reg
    import seq_detect_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] word_i,
    output logic             next_bit_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d    = shreg_q;
        next_bit_o = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        if (load_i) begin
            next_bit_o = MSB_FIRST ? word_i[WIDTH-1] : word_i[0];
            if (MSB_FIRST) begin
                shreg_d = {word_i[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, word_i[WIDTH-1:1]};
            end
        end else if (shift_i) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/sequence_word_serializer.sv
// Accepts parallel words over valid/ready and streams them one bit per clock on sequence_out.
// A new word can be accepted on the last bit of the previous one, so streams have no gaps.
module sequence_word_serializer
    import seq_detect_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             sequence_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             seq_out_q, seq_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             load, shift, next_bit, accept, at_last;

    serializer_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clock      (clock),
        .reset      (reset),
        .load_i     (load),
        .shift_i    (shift),
        .word_i     (word_in),
        .next_bit_o (next_bit)
    );

    // Reset gates ready so a word offered during reset is never taken.
    assign at_last    = (bit_cnt_q == LAST_CNT);
    assign word_ready = !reset && ((state_q == ST_IDLE) || (state_q == ST_SHIFT && at_last));
    assign accept     = word_valid && word_ready;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        load        = 1'b0;
        shift       = 1'b0;
        bit_valid_d = 1'b0;
        seq_out_d   = IDLE_BIT;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_SHIFT;
                    bit_cnt_d   = '0;
                    load        = 1'b1;
                    bit_valid_d = 1'b1;
                    seq_out_d   = next_bit;
                end
            end
            ST_SHIFT: begin
                if (!at_last) begin
                    bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                    shift       = 1'b1;
                    bit_valid_d = 1'b1;
                    seq_out_d   = next_bit;
                end else if (accept) begin
                    bit_cnt_d   = '0;
                    load        = 1'b1;
                    bit_valid_d = 1'b1;
                    seq_out_d   = next_bit;
                end else begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            seq_out_q   <= IDLE_BIT;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            seq_out_q   <= seq_out_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    assign sequence_out = seq_out_q;
    assign bit_valid    = bit_valid_q;
    assign word_done    = bit_valid_q && at_last;
    assign busy         = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_sequence_word_serializer.sv
// Scoreboard bench driving an MSB-first and an LSB-first serializer from one shared word stream.
// A monitor pops expected bits per instance and counts 1011 occurrences on the MSB-first stream.
module tb_sequence_word_serializer;

    logic       clock;
    logic       reset;
    logic [7:0] word_in;
    logic       word_valid;

    logic readyM, seqM, bvM, doneM, busyM;
    logic readyL, seqL, bvL, doneL, busyL;

    int total = 0;
    int bad   = 0;

    logic [1:0] qMsb[$];
    logic [1:0] qLsb[$];

    int         detCount = 0;
    int         runLen   = 0;
    int         maxRun   = 0;
    logic [3:0] hist     = 4'b0000;

    sequence_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dutMsb (
        .clock(clock), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .word_ready(readyM), .sequence_out(seqM), .bit_valid(bvM),
        .word_done(doneM), .busy(busyM)
    );

    sequence_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dutLsb (
        .clock(clock), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .word_ready(readyL), .sequence_out(seqL), .bit_valid(bvL),
        .word_done(doneL), .busy(busyL)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle check of one instance against its queue and the handshake rules.
    task automatic checkOutput(input int which, input logic seq, input logic bv,
                               input logic wd, input logic wr, input logic bsy);
        logic [1:0] e;
        string      tag;
        tag = (which == 0) ? "msb" : "lsb";
        if (reset) begin
            checkEq({tag, "_reset_seq"},   seq, 1'b0);
            checkEq({tag, "_reset_valid"}, bv,  1'b0);
            checkEq({tag, "_reset_done"},  wd,  1'b0);
            checkEq({tag, "_reset_busy"},  bsy, 1'b0);
            checkEq({tag, "_reset_ready"}, wr,  1'b0);
        end else if (bv) begin
            if ((which == 0 && qMsb.size() == 0) || (which == 1 && qLsb.size() == 0)) begin
                checkEq({tag, "_unexpected_bit"}, 1'b1, 1'b0);
            end else begin
                e = (which == 0) ? qMsb.pop_front() : qLsb.pop_front();
                checkEq({tag, "_bit"},  seq, e[0]);
                checkEq({tag, "_done"}, wd,  e[1]);
            end
            checkEq({tag, "_busy_while_valid"}, bsy, 1'b1);
            checkEq({tag, "_ready_shift"}, wr, wd);
        end else begin
            checkEq({tag, "_idle_seq"},   seq, 1'b0);
            checkEq({tag, "_idle_done"},  wd,  1'b0);
            checkEq({tag, "_idle_ready"}, wr,  1'b1);
        end
    endtask

    // Monitor samples 2 time units after the active edge.
    always begin
        @(posedge clock);
        #2;
        checkOutput(0, seqM, bvM, doneM, readyM, busyM);
        checkOutput(1, seqL, bvL, doneL, readyL, busyL);
        if (reset) begin
            hist   = 4'b0000;
            runLen = 0;
        end else begin
            hist = {hist[2:0], seqM};
            if (hist == 4'b1011) detCount++;
            runLen = bvM ? runLen + 1 : 0;
            if (runLen > maxRun) maxRun = runLen;
        end
    end

    // Offers a word and returns right after the edge on which it is accepted.
    task automatic applyStimulus(input logic [7:0] w);
        int budget;
        budget = 0;
        @(negedge clock);
        word_in    = w;
        word_valid = 1'b1;
        #1;
        while (!readyM && budget < 50) begin
            @(negedge clock);
            #1;
            budget++;
        end
        if (!readyM) begin
            checkEq("ready_timeout", 1'b0, 1'b1);
        end else begin
            for (int i = 0; i < 8; i++) begin
                qMsb.push_back({(i == 7), w[7 - i]});
                qLsb.push_back({(i == 7), w[i]});
            end
        end
        @(posedge clock);
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while ((qMsb.size() != 0 || qLsb.size() != 0) && budget < 100) begin
            @(negedge clock);
            budget++;
        end
        checkEq("drain_remaining", qMsb.size() + qLsb.size(), 0);
    endtask

    initial begin
        reset      = 1'b1;
        word_valid = 1'b0;
        word_in    = 8'h00;

        // Reset held three cycles with no traffic.
        repeat (3) begin
            @(negedge clock);
            checkEq("ready_in_reset", readyM, 1'b0);
        end
        reset = 1'b0;
        #1;
        checkEq("ready_after_reset", readyM, 1'b1);

        // Single MSB-first word B0 -> 1011 0000, one detection.
        detCount = 0;
        applyStimulus(8'hB0);
        @(negedge clock);
        word_valid = 1'b0;
        waitDrain();
        @(negedge clock);
        checkEq("single_idle_busy", busyM, 1'b0);
        checkEq("single_det_count", detCount, 1);

        // Back-to-back B0 then BB: 16 contiguous bits, three 1011 hits.
        repeat (2) @(negedge clock);
        detCount = 0;
        maxRun   = 0;
        applyStimulus(8'hB0);
        applyStimulus(8'hBB);
        @(negedge clock);
        word_valid = 1'b0;
        waitDrain();
        @(negedge clock);
        checkEq("b2b_run_len", maxRun, 16);
        checkEq("b2b_det_count", detCount, 3);

        // 0D: LSB-first instance sends 1,0,1,1,0,0,0,0.
        repeat (2) @(negedge clock);
        applyStimulus(8'h0D);
        @(negedge clock);
        word_valid = 1'b0;
        waitDrain();

        // Reset after three bits of FF abandons the word.
        repeat (2) @(negedge clock);
        applyStimulus(8'hFF);
        @(negedge clock);
        word_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        qMsb.delete();
        qLsb.delete();
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(8'hB0);
        @(negedge clock);
        word_valid = 1'b0;
        waitDrain();

        // Word offered mid-word is held off until the last bit; earlier word_in values ignored.
        repeat (2) @(negedge clock);
        applyStimulus(8'hB0);
        @(negedge clock);
        word_valid = 1'b0;
        repeat (2) @(negedge clock);
        word_valid = 1'b1;
        word_in    = 8'hFF;
        #1;
        checkEq("busy_at_cnt2", busyM, 1'b1);
        checkEq("ready_at_cnt2", readyM, 1'b0);
        @(negedge clock);
        word_in = 8'h00;
        applyStimulus(8'h0D);
        @(negedge clock);
        word_valid = 1'b0;
        waitDrain();
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
